// File: rtl/status_register_unit.sv
// -----------------------------------------------------------------------------
// status_register_unit
//
// Captures an adder result and its status flags into a single-entry
// valid/ready holding register. It evaluates a selectable condition code on
// the held flags and keeps a sticky overflow bit plus saturating
// overflow/carry event counters.
//
// Ports
//   clk, rst        : clock; synchronous active-high reset
//   in_valid        : a result and flags are offered this cycle
//   in_ready        : the offered result is taken (!out_valid || out_ready)
//   z_in            : adder sum, WIDTH bits
//   sign_in, zero_in, overflow_in, carry_in, parity_in : adder flags
//   out_valid       : the held entry is valid
//   out_ready       : downstream consumes the held entry
//   result_out      : held sum
//   flags_out       : held flags {sign,zero,overflow,carry,parity}
//   cond_sel        : condition code select (0 always, 1 z, 2 !z, 3 s,
//                     4 !s, 5 ovf, 6 carry, 7 parity)
//   cond_true       : selected condition on the held flags
//   sticky_ovf      : an overflow was accepted since the last clear
//   clr             : clears sticky_ovf and both counters
//   ovf_count       : saturating count of accepted overflows
//   carry_count     : saturating count of accepted carries
// -----------------------------------------------------------------------------
module status_register_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] z_in,
    input  logic             sign_in,
    input  logic             zero_in,
    input  logic             overflow_in,
    input  logic             carry_in,
    input  logic             parity_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_out,
    output logic [4:0]       flags_out,
    input  logic [2:0]       cond_sel,
    output logic             cond_true,
    output logic             sticky_ovf,
    input  logic             clr,
    output logic [CNT_W-1:0] ovf_count,
    output logic [CNT_W-1:0] carry_count
);

    // Bit positions inside the packed flag vector
    localparam int FLG_SIGN   = 4;
    localparam int FLG_ZERO   = 3;
    localparam int FLG_OVF    = 2;
    localparam int FLG_CARRY  = 1;
    localparam int FLG_PARITY = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [4:0]        flags_q, flags_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]  carry_cnt_q, carry_cnt_d;
    logic [CNT_W-1:0]  ovf_base, carry_base;
    logic              accept;
    logic              consume;
    logic              cond_raw;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Next state for the holding register. Data only moves on accept, so the
    // held entry stays stable under backpressure.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (accept) begin
            state_d  = ST_FULL;
            result_d = z_in;
            flags_d  = {sign_in, zero_in, overflow_in, carry_in, parity_in};
        end else if (consume) begin
            state_d  = ST_EMPTY;
        end
    end

    // Clear is applied first and the accepted event is layered on top, so an
    // event arriving together with clr still counts as one.
    always_comb begin
        ovf_base    = clr ? '0 : ovf_cnt_q;
        carry_base  = clr ? '0 : carry_cnt_q;
        sticky_d    = (clr ? 1'b0 : sticky_q) | (accept & overflow_in);
        ovf_cnt_d   = (accept && overflow_in) ? sat_inc(ovf_base) : ovf_base;
        carry_cnt_d = (accept && carry_in) ? sat_inc(carry_base) : carry_base;
    end

    always_comb begin
        cond_raw = 1'b1;
        case (cond_sel)
            3'd0:    cond_raw = 1'b1;
            3'd1:    cond_raw = flags_q[FLG_ZERO];
            3'd2:    cond_raw = !flags_q[FLG_ZERO];
            3'd3:    cond_raw = flags_q[FLG_SIGN];
            3'd4:    cond_raw = !flags_q[FLG_SIGN];
            3'd5:    cond_raw = flags_q[FLG_OVF];
            3'd6:    cond_raw = flags_q[FLG_CARRY];
            default: cond_raw = flags_q[FLG_PARITY];
        endcase
    end

    // An empty register has no meaningful flags; only "always" may be true.
    assign cond_true = (cond_sel == 3'd0) ? 1'b1 : (out_valid & cond_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            result_q    <= '0;
            flags_q     <= '0;
            sticky_q    <= 1'b0;
            ovf_cnt_q   <= '0;
            carry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            sticky_q    <= sticky_d;
            ovf_cnt_q   <= ovf_cnt_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign result_out  = result_q;
    assign flags_out   = flags_q;
    assign sticky_ovf  = sticky_q;
    assign ovf_count   = ovf_cnt_q;
    assign carry_count = carry_cnt_q;

endmodule

// File: tb/tb_status_register_unit.sv
// -----------------------------------------------------------------------------
// tb_status_register_unit
//
// Directed stimulus for status_register_unit. The driver pushes each entry it
// expects to be accepted into a scoreboard queue; a separate monitor compares
// the held entry against the queue head whenever out_valid is high and pops
// it when the entry is consumed. Control outputs (in_ready, cond_true,
// sticky_ovf, counters) are compared against a small reference model and a
// set of hand-computed constants.
// -----------------------------------------------------------------------------
module tb_status_register_unit;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] z_in;
    logic             sign_in, zero_in, overflow_in, carry_in, parity_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_out;
    logic [4:0]       flags_out;
    logic [2:0]       cond_sel;
    logic             cond_true;
    logic             sticky_ovf;
    logic             clr;
    logic [CNT_W-1:0] ovf_count;
    logic [CNT_W-1:0] carry_count;

    always #5 clk = ~clk;

    status_register_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .z_in        (z_in),
        .sign_in     (sign_in),
        .zero_in     (zero_in),
        .overflow_in (overflow_in),
        .carry_in    (carry_in),
        .parity_in   (parity_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_out  (result_out),
        .flags_out   (flags_out),
        .cond_sel    (cond_sel),
        .cond_true   (cond_true),
        .sticky_ovf  (sticky_ovf),
        .clr         (clr),
        .ovf_count   (ovf_count),
        .carry_count (carry_count)
    );

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic [4:0]       f;
    } entry_t;

    entry_t sb_q[$];

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic       m_full;
    logic       m_sticky;
    logic [4:0] m_flags;
    logic [7:0] m_ovf;
    logic [7:0] m_carry;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_cond(input logic [2:0] sel, input logic full, input logic [4:0] f);
        logic r;
        case (sel)
            3'd0:    r = 1'b1;
            3'd1:    r = f[3];
            3'd2:    r = !f[3];
            3'd3:    r = f[4];
            3'd4:    r = !f[4];
            3'd5:    r = f[2];
            3'd6:    r = f[1];
            default: r = f[0];
        endcase
        return (sel == 3'd0) ? 1'b1 : (full & r);
    endfunction

    // One clock of stimulus: check registered state from the previous edge,
    // apply new inputs, check combinational outputs, advance the model.
    task automatic cyc(input logic v, input logic [15:0] z, input logic [4:0] f,
                       input logic ordy, input logic c, input logic r,
                       input logic [2:0] sel);
        logic pred_rdy, acc, cons;
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_full);
        chk("sticky_ovf", sticky_ovf, m_sticky);
        chk("ovf_count", ovf_count, m_ovf);
        chk("carry_count", carry_count, m_carry);
        in_valid  = v;
        z_in      = z;
        {sign_in, zero_in, overflow_in, carry_in, parity_in} = f;
        out_ready = ordy;
        clr       = c;
        rst       = r;
        cond_sel  = sel;
        #1;
        pred_rdy = !m_full || ordy;
        chk("in_ready", in_ready, pred_rdy);
        chk("cond_true", cond_true, m_cond(sel, m_full, m_flags));
        acc  = v && pred_rdy;
        cons = m_full && ordy;
        if (r) begin
            m_full   = 1'b0;
            m_flags  = 5'b0;
            m_sticky = 1'b0;
            m_ovf    = 8'h00;
            m_carry  = 8'h00;
            sb_q.delete();
        end else begin
            if (acc) begin
                sb_q.push_back({z, f});
                m_flags = f;
                m_full  = 1'b1;
            end else if (cons) begin
                m_full = 1'b0;
            end
            if (c) begin
                m_sticky = 1'b0;
                m_ovf    = 8'h00;
                m_carry  = 8'h00;
            end
            if (acc && f[2]) begin
                m_sticky = 1'b1;
                if (m_ovf != 8'hff) m_ovf++;
            end
            if (acc && f[1] && (m_carry != 8'hff)) m_carry++;
        end
    endtask

    // Scoreboard monitor: the held entry must match the queue head every cycle
    // it is valid (so it is also checked for stability under backpressure).
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_empty: got result %0h with no expected entry", result_out);
            end else begin
                chk("result_out", result_out, sb_q[0].z);
                chk("flags_out", flags_out, sb_q[0].f);
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; z_in = '0; out_ready = 1'b0; clr = 1'b0;
        {sign_in, zero_in, overflow_in, carry_in, parity_in} = 5'b0;
        cond_sel = 3'd0;
        m_full = 1'b0; m_sticky = 1'b0; m_flags = 5'b0; m_ovf = 8'h00; m_carry = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result_out, 16'h0000);
        chk("rst_flags", flags_out, 5'b00000);
        chk("rst_counts", {sticky_ovf, ovf_count, carry_count}, 17'h0);
        chk("rst_in_ready", in_ready, 1'b1);

        // First accept: sign-only entry, held under backpressure
        cyc(1'b1, 16'h8fff, 5'b10000, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd3);
        chk("c3_cond_true", cond_true, 1'b1);
        chk("c3_in_ready", in_ready, 1'b0);
        chk("c3_result", result_out, 16'h8fff);

        // Zero entry offered while blocked for 3 cycles, then released
        repeat (3) cyc(1'b1, 16'h0000, 5'b01000, 1'b0, 1'b0, 1'b0, 3'd4);
        chk("bp_result", result_out, 16'h8fff);
        cyc(1'b1, 16'h0000, 5'b01000, 1'b1, 1'b0, 1'b0, 3'd1);
        cyc(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd1);
        chk("bp_zero_valid", out_valid, 1'b1);
        chk("bp_zero_result", result_out, 16'h0000);
        chk("bp_zero_cond", cond_true, 1'b1);

        // Empty register: non-zero selects read 0, select 0 reads 1
        cyc(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd2);
        chk("empty_cond2", cond_true, 1'b0);
        cyc(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("empty_cond0", cond_true, 1'b1);

        // Three overflow+carry accepts, then clear alone
        repeat (3) cyc(1'b1, 16'h7fff, 5'b00110, 1'b1, 1'b0, 1'b0, 3'd5);
        cyc(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("ev3_sticky", sticky_ovf, 1'b1);
        chk("ev3_ovf", ovf_count, 8'd3);
        chk("ev3_carry", carry_count, 8'd3);
        cyc(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0);
        cyc(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("clr_all", {sticky_ovf, ovf_count, carry_count}, 17'h0);

        // Clear together with an overflow accept: the event wins
        cyc(1'b1, 16'h7fff, 5'b00100, 1'b1, 1'b1, 1'b0, 3'd0);
        cyc(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd5);
        chk("clrev_sticky", sticky_ovf, 1'b1);
        chk("clrev_ovf", ovf_count, 8'd1);
        chk("clrev_carry", carry_count, 8'd0);

        // 260 back-to-back carry accepts, sweeping every condition select
        for (int i = 0; i < 260; i++)
            cyc(1'b1, 16'(i * 37), 5'b00010 | 5'(i & 5'h11), 1'b1, 1'b0, 1'b0, 3'(i));
        cyc(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("sat_carry", carry_count, 8'hff);
        chk("sat_ovf", ovf_count, 8'd1);

        // Reset while full and blocked discards the entry
        cyc(1'b1, 16'h1234, 5'b10101, 1'b0, 1'b0, 1'b0, 3'd7);
        cyc(1'b1, 16'h5555, 5'b01010, 1'b0, 1'b1, 1'b1, 3'd7);
        cyc(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd7);
        chk("rst2_valid", out_valid, 1'b0);
        chk("rst2_in_ready", in_ready, 1'b1);
        chk("rst2_result", result_out, 16'h0000);
        chk("rst2_flags", flags_out, 5'b00000);
        chk("rst2_counts", {sticky_ovf, ovf_count, carry_count}, 17'h0);
        chk("rst2_cond", cond_true, 1'b0);

        // Drain
        repeat (2) cyc(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
